// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm clock sequencer.
package alarm_pkg;

    localparam int TICK_W = 15;

    // 12:00:00.00 AM in HH MM SS FF BCD.
    localparam logic [31:0] BCD_MIDNIGHT = 32'h1200_0000;

    typedef enum logic [1:0] {
        MODE_RUN       = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_SET_ALARM = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        ALARM_IDLE    = 2'd0,
        ALARM_RINGING = 2'd1,
        ALARM_SNOOZE  = 2'd2
    } alarm_state_t;

endpackage

// File: rtl/button_repeat.sv
// Held-button auto-repeat: fires on the press edge, then after REPEAT_DELAY
// ticks, then every REPEAT_PERIOD ticks. fire is combinational; the caller registers it.
module button_repeat
    import alarm_pkg::*;
#(
    parameter int REPEAT_DELAY  = 50,
    parameter int REPEAT_PERIOD = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn,
    input  logic enable,
    output logic fire
);

    logic              btn_p1;
    logic              armed;
    logic              in_period;
    logic [TICK_W-1:0] cnt;
    logic [TICK_W-1:0] limit;
    logic              rise;
    logic              wrap;

    assign limit = in_period ? TICK_W'(REPEAT_PERIOD - 1) : TICK_W'(REPEAT_DELAY - 1);
    assign rise  = btn & ~btn_p1;
    assign wrap  = armed & btn & tick & (cnt == limit);
    assign fire  = enable & (rise | wrap);

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_p1    <= 1'b0;
            armed     <= 1'b0;
            in_period <= 1'b0;
            cnt       <= '0;
        end else begin
            btn_p1 <= btn;
            // Losing enable disarms; only a fresh press edge can re-arm.
            if (!enable || !btn) begin
                armed     <= 1'b0;
                in_period <= 1'b0;
                cnt       <= '0;
            end else if (rise) begin
                armed     <= 1'b1;
                in_period <= 1'b0;
                cnt       <= '0;
            end else if (armed && tick) begin
                if (cnt == limit) begin
                    cnt       <= '0;
                    in_period <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alarm_controller.sv
// Alarm clock sequencer: mode FSM, button auto-repeat routing, alarm ring/snooze FSM.
// Optional display blink strobe in set modes enabled by defining SET_BLINK_EN.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int REPEAT_DELAY  = 50,
    parameter int REPEAT_PERIOD = 10,
    parameter int RING_TIMEOUT  = 6000,
    parameter int SNOOZE_TICKS  = 30000
) (
    input  logic        i_Clk_5MHz,
    input  logic        i_Reset,
    input  logic        i_Clk_100Hz_Pulse,
    input  logic        i_Mode_Btn,
    input  logic        i_Minutes_Btn,
    input  logic        i_Hours_Btn,
    input  logic        i_Snooze_Btn,
    input  logic        i_Alarm_On_Sw,
    input  logic [31:0] i_Time,
    input  logic        i_Time_PM,
    input  logic [31:0] i_Alarm_Time,
    input  logic        i_Alarm_PM,
    output logic        o_Enable_Count,
    output logic        o_Time_Minutes_Inc,
    output logic        o_Time_Hours_Inc,
    output logic        o_Alarm_Minutes_Inc,
    output logic        o_Alarm_Hours_Inc,
    output logic        o_Show_Alarm,
    output logic        o_Buzzer,
    output logic        o_Blink
);

    mode_t             mode, mode_next;
    alarm_state_t      alarm_state, alarm_next;
    logic [TICK_W-1:0] alarm_timer, alarm_timer_next;
    logic              mode_btn_p1, snooze_btn_p1, match_p1;
    logic              mode_rise, snooze_rise, match, trigger, alarm_allowed;
    logic              setting, min_fire, hr_fire;
    logic              unused_alarm_low;

    assign mode_rise   = i_Mode_Btn & ~mode_btn_p1;
    assign snooze_rise = i_Snooze_Btn & ~snooze_btn_p1;
    // A mode edge suppresses repeat pulses so a held button cannot leak into the new mode.
    assign setting     = (mode != MODE_RUN) & ~mode_rise;

    assign match = (i_Time[31:16] == i_Alarm_Time[31:16]) & (i_Time_PM == i_Alarm_PM) &
                   (i_Time[15:0] == BCD_MIDNIGHT[15:0]);
    assign trigger          = match & ~match_p1;
    assign alarm_allowed    = i_Alarm_On_Sw & (mode_next == MODE_RUN);
    assign unused_alarm_low = ^i_Alarm_Time[15:0];

    button_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_min_repeat (
        .clk    (i_Clk_5MHz),
        .rst    (i_Reset),
        .tick   (i_Clk_100Hz_Pulse),
        .btn    (i_Minutes_Btn),
        .enable (setting & ~i_Hours_Btn),
        .fire   (min_fire)
    );

    button_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_hr_repeat (
        .clk    (i_Clk_5MHz),
        .rst    (i_Reset),
        .tick   (i_Clk_100Hz_Pulse),
        .btn    (i_Hours_Btn),
        .enable (setting),
        .fire   (hr_fire)
    );

    always_comb begin
        mode_next = mode;
        if (mode_rise) begin
            case (mode)
                MODE_RUN:      mode_next = MODE_SET_TIME;
                MODE_SET_TIME: mode_next = MODE_SET_ALARM;
                default:       mode_next = MODE_RUN;
            endcase
        end
    end

    always_comb begin
        alarm_next       = alarm_state;
        alarm_timer_next = alarm_timer;
        if (!alarm_allowed) begin
            alarm_next       = ALARM_IDLE;
            alarm_timer_next = '0;
        end else begin
            case (alarm_state)
                ALARM_IDLE: begin
                    if (trigger) begin
                        alarm_next       = ALARM_RINGING;
                        alarm_timer_next = '0;
                    end
                end
                ALARM_RINGING: begin
                    if (trigger) begin
                        alarm_timer_next = '0;
                    end else if (snooze_rise) begin
                        alarm_next       = ALARM_SNOOZE;
                        alarm_timer_next = '0;
                    end else if (i_Clk_100Hz_Pulse) begin
                        if (alarm_timer == TICK_W'(RING_TIMEOUT - 1)) begin
                            alarm_next       = ALARM_IDLE;
                            alarm_timer_next = '0;
                        end else begin
                            alarm_timer_next = alarm_timer + 1'b1;
                        end
                    end
                end
                ALARM_SNOOZE: begin
                    if (trigger) begin
                        alarm_next       = ALARM_RINGING;
                        alarm_timer_next = '0;
                    end else if (i_Clk_100Hz_Pulse) begin
                        if (alarm_timer == TICK_W'(SNOOZE_TICKS - 1)) begin
                            alarm_next       = ALARM_RINGING;
                            alarm_timer_next = '0;
                        end else begin
                            alarm_timer_next = alarm_timer + 1'b1;
                        end
                    end
                end
                default: begin
                    alarm_next       = ALARM_IDLE;
                    alarm_timer_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_Clk_5MHz) begin
        if (i_Reset) begin
            mode                <= MODE_RUN;
            alarm_state         <= ALARM_IDLE;
            alarm_timer         <= '0;
            mode_btn_p1         <= 1'b0;
            snooze_btn_p1       <= 1'b0;
            match_p1            <= 1'b0;
            o_Enable_Count      <= 1'b1;
            o_Show_Alarm        <= 1'b0;
            o_Buzzer            <= 1'b0;
            o_Time_Minutes_Inc  <= 1'b0;
            o_Time_Hours_Inc    <= 1'b0;
            o_Alarm_Minutes_Inc <= 1'b0;
            o_Alarm_Hours_Inc   <= 1'b0;
        end else begin
            mode                <= mode_next;
            alarm_state         <= alarm_next;
            alarm_timer         <= alarm_timer_next;
            mode_btn_p1         <= i_Mode_Btn;
            snooze_btn_p1       <= i_Snooze_Btn;
            match_p1            <= match;
            o_Enable_Count      <= (mode_next == MODE_RUN);
            o_Show_Alarm        <= (mode_next == MODE_SET_ALARM);
            o_Buzzer            <= (alarm_next == ALARM_RINGING);
            o_Time_Minutes_Inc  <= min_fire & (mode == MODE_SET_TIME);
            o_Time_Hours_Inc    <= hr_fire & (mode == MODE_SET_TIME);
            o_Alarm_Minutes_Inc <= min_fire & (mode == MODE_SET_ALARM);
            o_Alarm_Hours_Inc   <= hr_fire & (mode == MODE_SET_ALARM);
        end
    end

`ifdef SET_BLINK_EN
    logic [4:0] blink_cnt;
    logic       blink_ph;
    logic [5:0] quiet_cnt;

    // quiet_cnt saturates at 50 ticks since the last repeat pulse; blanking only allowed then.
    always_ff @(posedge i_Clk_5MHz) begin
        if (i_Reset || mode_next == MODE_RUN) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
            quiet_cnt <= 6'd50;
            o_Blink   <= 1'b0;
        end else begin
            if (min_fire || hr_fire) begin
                quiet_cnt <= '0;
            end else if (i_Clk_100Hz_Pulse && quiet_cnt != 6'd50) begin
                quiet_cnt <= quiet_cnt + 1'b1;
            end
            if (i_Clk_100Hz_Pulse) begin
                if (blink_cnt == 5'd24) begin
                    blink_cnt <= '0;
                    blink_ph  <= ~blink_ph;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
            o_Blink <= blink_ph & (quiet_cnt == 6'd50) & ~(min_fire | hr_fire);
        end
    end
`else
    assign o_Blink = 1'b0;
`endif

endmodule
